// File: rtl/cpu_pkg.sv
// cpu_pkg: shared width constants and state encodings for the CPU program loader
package cpu_pkg;

  localparam int OPCODE_W = 3;
  localparam int REG_W    = 4;
  localparam int ADDR_W   = 4;
  localparam int MEM_REGS = 16;

  typedef enum logic [1:0] {IDLE, LOAD, WRITE, DONE} ctrl_state_t;

  typedef enum logic [2:0] {RX_IDLE, RX_START, RX_DATA, RX_STOP, RX_WAIT} rx_state_t;

endpackage

// File: rtl/uart_rx.sv
// uart_rx: 8N1 LSB-first receiver with glitch rejection and stop-bit framing check
module uart_rx import cpu_pkg::*; #(
  parameter int CLKS_PER_BIT = 1042
) (
  input  logic       clk_i,
  input  logic       reset_ni,
  input  logic       en_i,
  input  logic       rx_i,
  output logic [7:0] byte_o,
  output logic       valid_o,
  output logic       frame_err_o
);

  localparam int CW = $clog2(CLKS_PER_BIT);

  rx_state_t      r_state;
  logic [CW-1:0]  r_cnt;
  logic [2:0]     r_bit;
  logic [7:0]     r_byte;
  logic           r_rx_d;
  logic           r_valid;
  logic           r_ferr;

  assign byte_o      = r_byte;
  assign valid_o     = r_valid;
  assign frame_err_o = r_ferr;

  // Start-edge detect, mid-bit sampling, and re-arm only once the line is back high
  always_ff @(posedge clk_i or negedge reset_ni) begin
    if (!reset_ni) begin
      r_state <= RX_IDLE;
      r_cnt   <= '0;
      r_bit   <= '0;
      r_byte  <= '0;
      r_rx_d  <= 1'b1;
      r_valid <= 1'b0;
      r_ferr  <= 1'b0;
    end else begin
      r_rx_d  <= rx_i;
      r_valid <= 1'b0;
      r_ferr  <= 1'b0;
      if (!en_i) begin
        r_state <= RX_IDLE;
        r_cnt   <= '0;
      end else begin
        case (r_state)
          RX_IDLE: begin
            if (r_rx_d && !rx_i) begin
              r_state <= RX_START;
              r_cnt   <= '0;
            end
          end
          RX_START: begin
            if (r_cnt == CW'(CLKS_PER_BIT / 2 - 1)) begin
              r_cnt   <= '0;
              r_bit   <= '0;
              r_state <= rx_i ? RX_IDLE : RX_DATA;
            end else r_cnt <= r_cnt + 1'b1;
          end
          RX_DATA: begin
            if (r_cnt == CW'(CLKS_PER_BIT - 1)) begin
              r_cnt  <= '0;
              r_byte <= {rx_i, r_byte[7:1]};
              r_bit  <= r_bit + 1'b1;
              if (r_bit == 3'd7) r_state <= RX_STOP;
            end else r_cnt <= r_cnt + 1'b1;
          end
          RX_STOP: begin
            if (r_cnt == CW'(CLKS_PER_BIT - 1)) begin
              r_cnt   <= '0;
              r_valid <= rx_i;
              r_ferr  <= !rx_i;
              r_state <= rx_i ? RX_IDLE : RX_WAIT;
            end else r_cnt <= r_cnt + 1'b1;
          end
          RX_WAIT: begin
            if (rx_i) r_state <= RX_IDLE;
          end
          default: r_state <= RX_IDLE;
        endcase
      end
    end
  end

endmodule

// File: rtl/program_load_controller.sv
// program_load_controller: halts the CPU and loads program words received over UART
module program_load_controller import cpu_pkg::*; #(
  parameter int CLKS_PER_BIT         = 1042,
  parameter int OPERATION_CODE_WIDTH = OPCODE_W,
  parameter int REGISTER_WIDTH       = REG_W,
  parameter int MEMORY_ADDRESS_WIDTH = ADDR_W,
  parameter int MEMORY_REGISTERS     = MEM_REGS
) (
  input  logic                                         clk_i,
  input  logic                                         reset_ni,
  input  logic                                         p_programm_i,
  input  logic                                         rx_i,
  output logic                                         cpu_halt_o,
  output logic                                         mem_we_o,
  output logic [MEMORY_ADDRESS_WIDTH-1:0]              mem_addr_o,
  output logic [OPERATION_CODE_WIDTH+REGISTER_WIDTH-1:0] mem_data_o,
  output logic                                         done_o,
  output logic                                         frame_err_o
);

  localparam int DW = OPERATION_CODE_WIDTH + REGISTER_WIDTH;

  ctrl_state_t                 r_state;
  logic [MEMORY_ADDRESS_WIDTH-1:0] r_cnt;
  logic [MEMORY_ADDRESS_WIDTH-1:0] r_addr;
  logic [DW-1:0]               r_data;
  logic                        r_halt;
  logic                        r_we;
  logic                        r_done;
  logic                        r_ferr;
  logic [7:0]                  w_rx_byte;
  logic                        w_rx_valid;
  logic                        w_rx_ferr;
  logic                        w_rx_en;
  logic                        w_last;

  assign w_rx_en     = (r_state == LOAD) || (r_state == WRITE);
  assign w_last      = r_cnt == MEMORY_ADDRESS_WIDTH'(MEMORY_REGISTERS - 1);
  assign cpu_halt_o  = r_halt;
  assign mem_we_o    = r_we;
  assign mem_addr_o  = r_addr;
  assign mem_data_o  = r_data;
  assign done_o      = r_done;
  assign frame_err_o = r_ferr;

  uart_rx #(.CLKS_PER_BIT(CLKS_PER_BIT)) u_rx (
    .clk_i       (clk_i),
    .reset_ni    (reset_ni),
    .en_i        (w_rx_en),
    .rx_i        (rx_i),
    .byte_o      (w_rx_byte),
    .valid_o     (w_rx_valid),
    .frame_err_o (w_rx_ferr)
  );

  // Load session FSM: strobes and halt are registered so they align with the state
  always_ff @(posedge clk_i or negedge reset_ni) begin
    if (!reset_ni) begin
      r_state <= IDLE;
      r_cnt   <= '0;
      r_addr  <= '0;
      r_data  <= '0;
      r_halt  <= 1'b0;
      r_we    <= 1'b0;
      r_done  <= 1'b0;
      r_ferr  <= 1'b0;
    end else begin
      r_we   <= 1'b0;
      r_done <= 1'b0;
      case (r_state)
        IDLE: begin
          r_halt <= p_programm_i;
          if (p_programm_i) begin
            r_state <= LOAD;
            r_cnt   <= '0;
            r_ferr  <= 1'b0;
          end
        end
        LOAD: begin
          if (!p_programm_i) begin
            r_state <= IDLE;
            r_cnt   <= '0;
            r_halt  <= 1'b0;
          end else if (w_rx_valid) begin
            r_state <= WRITE;
            r_we    <= 1'b1;
            r_done  <= w_last;
            r_addr  <= r_cnt;
            r_data  <= DW'(w_rx_byte & 8'h7F);
          end else if (w_rx_ferr) r_ferr <= 1'b1;
        end
        WRITE: begin
          r_cnt   <= r_cnt + 1'b1;
          r_state <= w_last ? DONE : LOAD;
        end
        DONE: begin
          if (!p_programm_i) begin
            r_state <= IDLE;
            r_halt  <= 1'b0;
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_program_load_controller.sv
// tb_program_load_controller: directed table and sequence checks of the UART program loader
module tb_program_load_controller;

  localparam int CPB = 8;

  typedef struct {
    logic [7:0] b;
    logic       stop;
    logic       we;
    logic [3:0] addr;
    logic [6:0] data;
    logic       ferr;
  } vec_t;

  logic       clk = 1'b0;
  logic       reset_ni = 1'b0;
  logic       p_programm_i = 1'b0;
  logic       rx_i = 1'b1;
  logic       cpu_halt_o;
  logic       mem_we_o;
  logic [3:0] mem_addr_o;
  logic [6:0] mem_data_o;
  logic       done_o;
  logic       frame_err_o;

  int n_checks = 0;
  int n_err = 0;
  int wr_n = 0;
  int done_n = 0;
  int done_addr = -1;
  int halt_low = 0;
  int stray_done = 0;
  logic halt_watch = 1'b0;
  logic [3:0] last_addr;
  logic [6:0] last_data;
  vec_t vecs[4];

  program_load_controller #(.CLKS_PER_BIT(CPB)) dut (
    .clk_i        (clk),
    .reset_ni     (reset_ni),
    .p_programm_i (p_programm_i),
    .rx_i         (rx_i),
    .cpu_halt_o   (cpu_halt_o),
    .mem_we_o     (mem_we_o),
    .mem_addr_o   (mem_addr_o),
    .mem_data_o   (mem_data_o),
    .done_o       (done_o),
    .frame_err_o  (frame_err_o)
  );

  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (mem_we_o) begin
      wr_n++;
      last_addr = mem_addr_o;
      last_data = mem_data_o;
    end
    if (done_o) begin
      done_n++;
      done_addr = int'(mem_addr_o);
    end
    if (done_o && !mem_we_o) stray_done++;
    if (halt_watch && !cpu_halt_o) halt_low++;
  end

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", name, got, exp);
    end
  endtask

  task automatic tx_bit(input logic v);
    rx_i = v;
    repeat (CPB) @(negedge clk);
  endtask

  task automatic send_byte(input logic [7:0] b, input logic stop);
    tx_bit(1'b0);
    for (int i = 0; i < 8; i++) tx_bit(b[i]);
    tx_bit(stop);
    if (!stop) tx_bit(1'b1);
  endtask

  task automatic start_session();
    p_programm_i = 1'b1;
    repeat (3) @(negedge clk);
  endtask

  initial begin
    int w0;
    vecs[0] = '{8'hFF, 1'b1, 1'b1, 4'd0, 7'h7F, 1'b0};
    vecs[1] = '{8'h35, 1'b0, 1'b0, 4'd0, 7'h00, 1'b1};
    vecs[2] = '{8'h12, 1'b1, 1'b1, 4'd1, 7'h12, 1'b1};
    vecs[3] = '{8'h80, 1'b1, 1'b1, 4'd2, 7'h00, 1'b1};

    repeat (3) @(negedge clk);
    check("reset_halt", 32'(cpu_halt_o), 0);
    check("reset_we", 32'(mem_we_o), 0);
    check("reset_addr", 32'(mem_addr_o), 0);
    check("reset_data", 32'(mem_data_o), 0);
    check("reset_done", 32'(done_o), 0);
    check("reset_ferr", 32'(frame_err_o), 0);
    reset_ni = 1'b1;
    repeat (5) @(negedge clk);
    check("idle_halt", 32'(cpu_halt_o), 0);

    start_session();
    check("session1_halt", 32'(cpu_halt_o), 1);
    for (int i = 0; i < 4; i++) begin
      w0 = wr_n;
      send_byte(vecs[i].b, vecs[i].stop);
      repeat (2) @(negedge clk);
      check($sformatf("vec%0d_writes", i), 32'(wr_n - w0), 32'(vecs[i].we));
      if (vecs[i].we) begin
        check($sformatf("vec%0d_addr", i), 32'(last_addr), 32'(vecs[i].addr));
        check($sformatf("vec%0d_data", i), 32'(last_data), 32'(vecs[i].data));
      end
      check($sformatf("vec%0d_ferr", i), 32'(frame_err_o), 32'(vecs[i].ferr));
    end
    check("addr_hold", 32'(mem_addr_o), 2);
    check("we_idle", 32'(mem_we_o), 0);
    p_programm_i = 1'b0;
    @(negedge clk);
    check("s1_exit_halt", 32'(cpu_halt_o), 0);
    repeat (4) @(negedge clk);

    start_session();
    check("ferr_cleared", 32'(frame_err_o), 0);
    w0 = wr_n;
    rx_i = 1'b0;
    repeat (3) @(negedge clk);
    rx_i = 1'b1;
    repeat (20) @(negedge clk);
    check("glitch_writes", 32'(wr_n - w0), 0);
    check("glitch_ferr", 32'(frame_err_o), 0);

    halt_watch = 1'b1;
    done_n = 0;
    for (int i = 0; i < 16; i++) begin
      w0 = wr_n;
      send_byte(8'(i), 1'b1);
      if (wr_n - w0 != 1 || last_addr != 4'(i) || last_data != 7'(i)) begin
        n_err++;
        $display("FAIL load16_word%0d: writes %0d addr %0h data %0h expected 1 write addr %0h data %0h",
                 i, wr_n - w0, last_addr, last_data, i, i);
      end
      n_checks++;
      if (i == 14) check("done_early", 32'(done_n), 0);
    end
    repeat (2) @(negedge clk);
    check("done_count", 32'(done_n), 1);
    check("done_addr", 32'(done_addr), 15);
    check("halt_throughout", 32'(halt_low), 0);
    w0 = wr_n;
    send_byte(8'h33, 1'b1);
    repeat (2) @(negedge clk);
    check("done_ignore_writes", 32'(wr_n - w0), 0);
    check("done_ignore_done", 32'(done_n), 1);
    check("done_halt", 32'(cpu_halt_o), 1);
    halt_watch = 1'b0;
    p_programm_i = 1'b0;
    @(negedge clk);
    check("done_exit_halt", 32'(cpu_halt_o), 0);
    repeat (4) @(negedge clk);

    start_session();
    for (int i = 0; i < 5; i++) send_byte(8'(8'h40 + i), 1'b1);
    check("pre_abort_addr", 32'(last_addr), 4);
    w0 = wr_n;
    tx_bit(1'b0);
    for (int i = 0; i < 4; i++) tx_bit(1'b1);
    p_programm_i = 1'b0;
    @(negedge clk);
    check("abort_halt", 32'(cpu_halt_o), 0);
    rx_i = 1'b1;
    repeat (50) @(negedge clk);
    check("abort_writes", 32'(wr_n - w0), 0);
    check("abort_halt_stays", 32'(cpu_halt_o), 0);
    start_session();
    send_byte(8'h55, 1'b1);
    repeat (2) @(negedge clk);
    check("restart_addr", 32'(last_addr), 0);
    check("restart_data", 32'(last_data), 32'h55);
    p_programm_i = 1'b0;
    repeat (4) @(negedge clk);

    start_session();
    for (int i = 0; i < 9; i++) send_byte(8'(8'h60 + i), 1'b1);
    w0 = wr_n;
    tx_bit(1'b0);
    tx_bit(1'b1);
    tx_bit(1'b0);
    @(posedge clk);
    #3;
    reset_ni = 1'b0;
    #1;
    check("rst_async_halt", 32'(cpu_halt_o), 0);
    check("rst_async_addr", 32'(mem_addr_o), 0);
    check("rst_async_data", 32'(mem_data_o), 0);
    check("rst_async_we", 32'({mem_we_o, done_o, frame_err_o}), 0);
    p_programm_i = 1'b0;
    @(negedge clk);
    reset_ni = 1'b1;
    for (int i = 0; i < 6; i++) tx_bit(1'b1);
    check("post_rst_writes", 32'(wr_n - w0), 0);
    check("post_rst_halt", 32'(cpu_halt_o), 0);
    start_session();
    send_byte(8'h2A, 1'b1);
    repeat (2) @(negedge clk);
    check("post_rst_addr", 32'(last_addr), 0);
    check("post_rst_data", 32'(last_data), 32'h2A);
    check("stray_done", 32'(stray_done), 0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
    $finish;
  end

endmodule

// File: doc/program_load_controller.md
PROGRAM_LOAD_CONTROLLER -- requirements
Module: program_load_controller

Interface
REQ-001 SHALL have parameter CLKS_PER_BIT, default 1042, UART bit period in clk_i cycles (>=4).
REQ-002 SHALL have parameter OPERATION_CODE_WIDTH, default 3, opcode field width.
REQ-003 SHALL have parameter REGISTER_WIDTH, default 4, operand field width.
REQ-004 SHALL have parameter MEMORY_ADDRESS_WIDTH, default 4, program memory address width.
REQ-005 SHALL have parameter MEMORY_REGISTERS, default 16, number of program words.
REQ-006 SHALL have port clk_i  input  1  single clock; all logic rising-edge.
REQ-007 SHALL have port reset_ni  input  1  reset, asynchronous, active-low.
REQ-008 SHALL have port p_programm_i  input  1  programming-mode request level, already synchronized.
REQ-009 SHALL have port rx_i  input  1  UART serial data, 8N1, LSB first, already synchronized, idle high.
REQ-010 SHALL have port cpu_halt_o  output  1  holds the CPU core stalled while high.
REQ-011 SHALL have port mem_we_o  output  1  program memory write strobe, one cycle per word.
REQ-012 SHALL have port mem_addr_o  output  MEMORY_ADDRESS_WIDTH  write address.
REQ-013 SHALL have port mem_data_o  output  OPERATION_CODE_WIDTH+REGISTER_WIDTH  write word (opcode in MSBs).
REQ-014 SHALL have port done_o  output  1  one-cycle pulse when the last word is written.
REQ-015 SHALL have port frame_err_o  output  1  sticky framing error flag.

Function
REQ-016 SHALL implement states IDLE, LOAD, WRITE, DONE.
REQ-017 IDLE: cpu_halt_o=0; p_programm_i=1 -> LOAD with address counter=0 and frame_err_o cleared.
REQ-018 LOAD/WRITE/DONE: cpu_halt_o=1, registered, asserted the cycle after LOAD entry.
REQ-019 In LOAD the receiver SHALL detect a falling rx_i edge and re-sample at CLKS_PER_BIT/2; if high, the edge is discarded as a glitch.
REQ-020 SHALL sample 8 data bits at CLKS_PER_BIT intervals from the start-bit midpoint, then the stop bit one period later.
REQ-021 Stop bit high -> WRITE for exactly one cycle: mem_we_o=1, mem_addr_o=counter, mem_data_o=byte[6:0]; byte[7] ignored.
REQ-022 After WRITE the counter SHALL increment; on writing address MEMORY_REGISTERS-1 -> DONE with done_o=1 for that cycle, else back to LOAD.
REQ-023 Stop bit low -> set frame_err_o, discard byte, counter unchanged, receiver waits for rx_i high before re-arming.
REQ-024 DONE: no further writes; received bytes ignored; p_programm_i=0 -> IDLE, cpu_halt_o=0 next cycle.
REQ-025 p_programm_i=0 in LOAD mid-byte SHALL abort: partial byte dropped, no write, IDLE next cycle, counter reset to 0.
REQ-026 mem_we_o and done_o SHALL never assert outside WRITE; mem_addr_o/mem_data_o hold last value otherwise.

Reset
REQ-027 reset_ni low SHALL asynchronously force IDLE, counter=0, receiver idle, cpu_halt_o=0, mem_we_o=0, mem_addr_o=0, mem_data_o=0, done_o=0, frame_err_o=0.
REQ-028 Reset mid-byte or mid-load SHALL leave no write pending after release; a new session begins only on p_programm_i=1.

Structure
REQ-029 Width constants (opcode, register, address, registers) and the controller state enum SHALL live in the shared cpu_pkg package.
REQ-030 The serial receiver SHALL be a sub-module uart_rx (outputs byte, valid pulse, frame_error pulse); the FSM and counter stay in program_load_controller.

Verification (bench CLKS_PER_BIT=8)
REQ-031 p_programm_i=1, send 16 bytes 0x00..0x0F -> 16 mem_we_o pulses, addr 0..15, data 0x00..0x0F, done_o after 16th, cpu_halt_o high throughout.
REQ-032 Send 0xFF -> mem_data_o=0x7F (bit7 dropped).
REQ-033 Byte 0x35 with stop bit low -> frame_err_o=1, no write, next good byte 0x12 written at same address.
REQ-034 3-cycle low glitch on rx_i -> no byte, no write, no error.
REQ-035 Drop p_programm_i after bit 4 of word 5 -> no write, IDLE, cpu_halt_o=0 next cycle; new session restarts at address 0.
REQ-036 reset_ni low during word 9 -> all outputs 0 immediately; after release nothing happens until p_programm_i=1.
